// File: rtl/fwd_track_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_track_pkg / fwd_track_if
// Description : Shared types and the decode/forwarding bundle of fwd_track.
// Revision    : 1.0 - initial release
// ============================================================================
package fwd_track_pkg;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [63:0] word_t;

    typedef struct packed {
        creg_addr_t dst;
        word_t      data;
        logic       ismem;
    } tran_t;
endpackage

interface fwd_track_if;
    import fwd_track_pkg::*;

    logic       dec_valid;
    creg_addr_t dec_dst;
    logic       dec_ismem;
    logic       bubble;
    logic       stall;
    logic       flush;
    word_t      exe_result;
    word_t      mem_rdata;
    tran_t      trand;
    tran_t      trane;
    tran_t      tranm;
    logic       issue;
    logic       wb_en;
    creg_addr_t wb_dst;
    word_t      wb_data;
    logic [63:0] instret;

    // Drives decode/control/data, observes forwarding and writeback.
    modport master (
        output dec_valid, dec_dst, dec_ismem, bubble, stall, flush,
               exe_result, mem_rdata,
        input  trand, trane, tranm, issue, wb_en, wb_dst, wb_data, instret
    );

    modport slave (
        input  dec_valid, dec_dst, dec_ismem, bubble, stall, flush,
               exe_result, mem_rdata,
        output trand, trane, tranm, issue, wb_en, wb_dst, wb_data, instret
    );
endinterface
`default_nettype wire

// File: rtl/fwd_track.sv
`default_nettype none
// ============================================================================
// Module      : fwd_track
// Description : X/E/M/W in-flight write tracker producing forwarding records,
//               the regfile write port and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_track
    import fwd_track_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    reset,
    fwd_track_if.slave   bus
);

    logic        r_x_valid, r_x_ismem;
    creg_addr_t  r_x_dst;
    logic        r_e_valid, r_e_ismem;
    creg_addr_t  r_e_dst;
    logic        r_m_valid, r_m_ismem;
    creg_addr_t  r_m_dst;
    word_t       r_m_data;
    logic        r_w_valid;
    creg_addr_t  r_w_dst;
    word_t       r_w_data;
    logic [63:0] r_instret;

    logic        w_issue;
    word_t       w_m_data;
    logic        w_x_live, w_e_live, w_m_live;

    assign w_issue  = bus.dec_valid & ~bus.bubble & ~bus.stall & ~bus.flush;
    // A load's value only exists on the memory read bus while it sits in M.
    assign w_m_data = r_m_ismem ? bus.mem_rdata : r_m_data;
    assign w_x_live = r_x_valid & (r_x_dst != 5'd0);
    assign w_e_live = r_e_valid & (r_e_dst != 5'd0);
    assign w_m_live = r_m_valid & (r_m_dst != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_valid <= 1'b0;
            r_x_dst   <= '0;
            r_x_ismem <= 1'b0;
            r_e_valid <= 1'b0;
            r_e_dst   <= '0;
            r_e_ismem <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_dst   <= '0;
            r_m_ismem <= 1'b0;
            r_m_data  <= '0;
            r_w_valid <= 1'b0;
            r_w_dst   <= '0;
            r_w_data  <= '0;
            r_instret <= '0;
        end else begin
            if (!bus.stall) begin
                r_w_valid <= r_m_valid;
                r_w_dst   <= r_m_dst;
                r_w_data  <= r_m_valid ? w_m_data : '0;
                r_m_valid <= r_e_valid;
                r_m_dst   <= r_e_dst;
                r_m_ismem <= r_e_ismem;
                r_m_data  <= r_e_valid ? bus.exe_result : '0;
                if (r_m_valid) begin
                    r_instret <= r_instret + 64'd1;
                end
            end
            // The redirecting branch itself is in E and still moves on to M.
            if (bus.flush) begin
                r_x_valid <= 1'b0;
                r_x_dst   <= '0;
                r_x_ismem <= 1'b0;
                r_e_valid <= 1'b0;
                r_e_dst   <= '0;
                r_e_ismem <= 1'b0;
            end else if (!bus.stall) begin
                r_e_valid <= r_x_valid;
                r_e_dst   <= r_x_dst;
                r_e_ismem <= r_x_ismem;
                r_x_valid <= w_issue;
                r_x_dst   <= w_issue ? bus.dec_dst : 5'd0;
                r_x_ismem <= w_issue ? bus.dec_ismem : 1'b0;
            end
        end
    end

    always_comb begin
        bus.trand = '0;
        bus.trane = '0;
        bus.tranm = '0;
        if (w_x_live) begin
            bus.trand.dst   = r_x_dst;
            bus.trand.ismem = r_x_ismem;
        end
        if (w_e_live) begin
            bus.trane.dst   = r_e_dst;
            bus.trane.data  = bus.exe_result;
            bus.trane.ismem = r_e_ismem;
        end
        if (w_m_live) begin
            bus.tranm.dst   = r_m_dst;
            bus.tranm.data  = w_m_data;
            bus.tranm.ismem = r_m_ismem;
        end
    end

    assign bus.issue   = w_issue;
    assign bus.wb_en   = r_w_valid & (r_w_dst != 5'd0);
    assign bus.wb_dst  = r_w_dst;
    assign bus.wb_data = r_w_data;
    assign bus.instret = r_instret;

endmodule
`default_nettype wire
